// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by the decode stage: opcodes, control-word field
// positions and the opcode -> control-word decode function.
package cpu_isa_pkg;

   localparam int CW_W  = 15;
   localparam int OPC_W = 7;

   // control word = {RW,MD[1:0],BS[1:0],PS,MW,FS[4:0],MB,MA,CS}
   localparam int CW_RW = 14;
   localparam int CW_MB = 2;
   localparam int CW_MA = 1;
   localparam int CW_CS = 0;

   localparam logic [OPC_W-1:0] OP_NOP = 7'h00;
   localparam logic [OPC_W-1:0] OP_ADD = 7'h02;
   localparam logic [OPC_W-1:0] OP_SUB = 7'h05;
   localparam logic [OPC_W-1:0] OP_SLT = 7'h65;
   localparam logic [OPC_W-1:0] OP_AND = 7'h08;
   localparam logic [OPC_W-1:0] OP_OR  = 7'h0A;
   localparam logic [OPC_W-1:0] OP_XOR = 7'h0C;
   localparam logic [OPC_W-1:0] OP_ST  = 7'h01;
   localparam logic [OPC_W-1:0] OP_LD  = 7'h21;
   localparam logic [OPC_W-1:0] OP_ADI = 7'h22;
   localparam logic [OPC_W-1:0] OP_SBI = 7'h25;
   localparam logic [OPC_W-1:0] OP_NOT = 7'h2E;
   localparam logic [OPC_W-1:0] OP_ANI = 7'h28;
   localparam logic [OPC_W-1:0] OP_ORI = 7'h2A;
   localparam logic [OPC_W-1:0] OP_XRI = 7'h2C;
   localparam logic [OPC_W-1:0] OP_AIU = 7'h62;
   localparam logic [OPC_W-1:0] OP_SIU = 7'h45;
   localparam logic [OPC_W-1:0] OP_MOV = 7'h40;
   localparam logic [OPC_W-1:0] OP_LSL = 7'h30;
   localparam logic [OPC_W-1:0] OP_LSR = 7'h31;
   localparam logic [OPC_W-1:0] OP_JMR = 7'h61;
   localparam logic [OPC_W-1:0] OP_BZ  = 7'h20;
   localparam logic [OPC_W-1:0] OP_BNZ = 7'h60;
   localparam logic [OPC_W-1:0] OP_JMP = 7'h44;
   localparam logic [OPC_W-1:0] OP_JML = 7'h07;

   typedef struct packed {
      logic [CW_W-1:0] cw;
      logic            illegal;
   } dec_t;

   // Unknown opcodes decode as NOP with the illegal flag set, never X.
   function automatic dec_t decode_op(input logic [OPC_W-1:0] opc);
      dec_t d;
      d.cw      = '0;
      d.illegal = 1'b0;
      case (opc)
         OP_NOP: d.cw = 15'h0000;
         OP_ADD: d.cw = 15'h4010;
         OP_SUB: d.cw = 15'h4028;
         OP_SLT: d.cw = 15'h6028;
         OP_AND: d.cw = 15'h4040;
         OP_OR:  d.cw = 15'h4050;
         OP_XOR: d.cw = 15'h4060;
         OP_ST:  d.cw = 15'h0100;
         OP_LD:  d.cw = 15'h5000;
         OP_ADI: d.cw = 15'h4015;
         OP_SBI: d.cw = 15'h402D;
         OP_NOT: d.cw = 15'h4070;
         OP_ANI: d.cw = 15'h4044;
         OP_ORI: d.cw = 15'h4054;
         OP_XRI: d.cw = 15'h4064;
         OP_AIU: d.cw = 15'h4014;
         OP_SIU: d.cw = 15'h402C;
         OP_MOV: d.cw = 15'h4000;
         OP_LSL: d.cw = 15'h4080;
         OP_LSR: d.cw = 15'h4088;
         OP_JMR: d.cw = 15'h0800;
         OP_BZ:  d.cw = 15'h0405;
         OP_BNZ: d.cw = 15'h0605;
         OP_JMP: d.cw = 15'h0C05;
         OP_JML: d.cw = 15'h4C3F;
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters. Issue increments, writeback and
// flush of a held writer decrement (floored at zero). Source queries see
// a writeback retiring in the same cycle as already done.
module reg_scoreboard #(
   parameter int REG_AW = 5,
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc_en,
   input  logic [REG_AW-1:0] inc_addr,
   input  logic              dec_en,
   input  logic [REG_AW-1:0] dec_addr,
   input  logic              fl_en,
   input  logic [REG_AW-1:0] fl_addr,
   input  logic [REG_AW-1:0] qa_addr,
   input  logic [REG_AW-1:0] qb_addr,
   input  logic [REG_AW-1:0] qd_addr,
   output logic              busy_a,
   output logic              busy_b,
   output logic              full_d
);

   localparam int NREG = 2**REG_AW;
   localparam logic [PEND_W-1:0] CNT_MAX = '1;

   logic [PEND_W-1:0] cnt     [NREG];
   logic [PEND_W-1:0] cnt_nxt [NREG];
   logic [PEND_W:0]   t;
   logic [PEND_W-1:0] cnt_a, cnt_b, cnt_d;
   logic              wb_a, wb_b, wb_d;

   assign cnt_a = cnt[qa_addr];
   assign cnt_b = cnt[qb_addr];
   assign cnt_d = cnt[qd_addr];
   assign wb_a  = dec_en && (dec_addr == qa_addr);
   assign wb_b  = dec_en && (dec_addr == qb_addr);
   assign wb_d  = dec_en && (dec_addr == qd_addr);

   // effective count = count minus a same-cycle writeback, floored at 0
   assign busy_a = cnt_a > {{(PEND_W-1){1'b0}}, wb_a};
   assign busy_b = cnt_b > {{(PEND_W-1){1'b0}}, wb_b};
   assign full_d = (cnt_d == CNT_MAX) && !wb_d;

   // next count per register: increment first, then each decrement with a zero floor
   always_comb begin
      t = '0;
      for (int r = 0; r < NREG; r++) begin
         t = {1'b0, cnt[r]} + {{PEND_W{1'b0}}, (inc_en && (inc_addr == REG_AW'(r)))};
         if (dec_en && (dec_addr == REG_AW'(r)) && (t != '0))
            t = t - (PEND_W+1)'(1);
         if (fl_en && (fl_addr == REG_AW'(r)) && (t != '0))
            t = t - (PEND_W+1)'(1);
         cnt_nxt[r] = t[PEND_W-1:0];
      end
   end

   // counter storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/pipelined_decode_stage.sv
// Registered, handshaked decode stage: slices IR, decodes the control word,
// extends the immediate and holds RAW hazards via the pending-write scoreboard.
module pipelined_decode_stage
   import cpu_isa_pkg::*;
#(
   parameter int IR_W   = 32,
   parameter int OPC_W  = 7,
   parameter int REG_AW = 5,
   parameter int DATA_W = 32,
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IR_W-1:0]   in_ir,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CW_W-1:0]   out_cw,
   output logic [REG_AW-1:0] out_da,
   output logic [REG_AW-1:0] out_aa,
   output logic [REG_AW-1:0] out_ba,
   output logic [DATA_W-1:0] out_imm,
   output logic              out_illegal,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_addr,
   output logic              stall
);

   localparam int IMM_W = IR_W - OPC_W - 2*REG_AW;

   logic [OPC_W-1:0]  opc;
   logic [REG_AW-1:0] da, aa, ba;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] imm_ext;
   dec_t              dec;
   logic [CW_W-1:0]   cw;
   logic              busy_a, busy_b, full_d;
   logic              hazard, in_hs, inc_en, fl_en;

   // the immediate field overlaps BA; instructions use one or the other
   assign opc = in_ir[IR_W-1 -: OPC_W];
   assign da  = in_ir[IR_W-OPC_W-1 -: REG_AW];
   assign aa  = in_ir[IR_W-OPC_W-REG_AW-1 -: REG_AW];
   assign ba  = in_ir[IR_W-OPC_W-2*REG_AW-1 -: REG_AW];
   assign imm = in_ir[IMM_W-1:0];

   assign dec = decode_op(opc);
   assign cw  = dec.cw;

   assign imm_ext = cw[CW_CS] ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                              : {{(DATA_W-IMM_W){1'b0}}, imm};

   // a saturated destination counter also holds issue so counts never wrap
   assign hazard   = (!cw[CW_MA] && busy_a) || (!cw[CW_MB] && busy_b) || (cw[CW_RW] && full_d);
   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign in_hs    = in_valid && in_ready;
   assign stall    = in_valid && hazard;
   assign inc_en   = in_hs && cw[CW_RW];

   // only a held entry that is not leaving this cycle gives back its pending write
   assign fl_en = flush && out_valid && !out_ready && out_cw[CW_RW];

   reg_scoreboard #(
      .REG_AW (REG_AW),
      .PEND_W (PEND_W)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_en   (inc_en),
      .inc_addr (da),
      .dec_en   (wb_valid),
      .dec_addr (wb_addr),
      .fl_en    (fl_en),
      .fl_addr  (out_da),
      .qa_addr  (aa),
      .qb_addr  (ba),
      .qd_addr  (da),
      .busy_a   (busy_a),
      .busy_b   (busy_b),
      .full_d   (full_d)
   );

   // output holding register: load on handshake, drop on flush or consume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_cw      <= '0;
         out_da      <= '0;
         out_aa      <= '0;
         out_ba      <= '0;
         out_imm     <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_hs) begin
         out_valid   <= 1'b1;
         out_cw      <= cw;
         out_da      <= da;
         out_aa      <= aa;
         out_ba      <= ba;
         out_imm     <= imm_ext;
         out_illegal <= dec.illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
